test_wr_ctrl_64bit: RTL and testbench

AXI3-style write-side traffic generator for the DDR3 example-design self-test, on the 64-bit AXI port of the DDR controller. It issues single write bursts of random address, ID and length. Each 16-bit lane carries a self-describing pattern (random byte plus that byte XOR the lane address), so the companion read checker can verify any read-back without stored expectations. It also checks write responses and counts errors.

---
 rtl/test_wr_ctrl_64bit_if.sv | 46 ++++
 rtl/test_wr_ctrl_64bit.sv | 155 +++++++++++++++
 tb/tb_test_wr_ctrl_64bit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_wr_ctrl_64bit_if.sv
// AXI3 write-channel bundle between the DDR3 self-test write
// generator (master) and the controller's 64-bit AXI port (slave).
interface test_wr_ctrl_64bit_if;
   logic [31:0] axi_awaddr;
   logic [7:0]  axi_awid;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic        axi_awlock;
   logic [3:0]  axi_awqos;
   logic        axi_awpoison;
   logic        axi_awurgent;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [63:0] axi_wdata;
   logic [7:0]  axi_wstrb;
   logic        axi_wlast;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [7:0]  axi_bid;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;

   modport master (
      output axi_awaddr, axi_awid, axi_awlen, axi_awsize,
      output axi_awburst, axi_awlock, axi_awqos,
      output axi_awpoison, axi_awurgent, axi_awvalid,
      input  axi_awready,
      output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      input  axi_wready,
      input  axi_bid, axi_bresp, axi_bvalid,
      output axi_bready
   );

   modport slave (
      input  axi_awaddr, axi_awid, axi_awlen, axi_awsize,
      input  axi_awburst, axi_awlock, axi_awqos,
      input  axi_awpoison, axi_awurgent, axi_awvalid,
      output axi_awready,
      input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      output axi_wready,
      output axi_bid, axi_bresp, axi_bvalid,
      input  axi_bready
   );
endinterface

// File: rtl/test_wr_ctrl_64bit.sv
// DDR3 self-test write generator: single random AXI3 write bursts
// with self-describing lane data, plus write-response error counting.
module test_wr_ctrl_64bit #(
   parameter int CTRL_ADDR_WIDTH = 28
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
   input  logic [3:0]                 random_axi_id,
   input  logic [3:0]                 random_axi_len,
   input  logic [7:0]                 random_data,
   input  logic                       write_en,
   input  logic                       data_pattern_01,
   output logic                       write_done_p,
   output logic [7:0]                 wr_err_cnt,
   output logic                       wr_err_flag,
   test_wr_ctrl_64bit_if.master       axi
);
   localparam int ADDR_NUM_BIT = 31 - CTRL_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AW   = 2'd1,
      W    = 2'd2,
      B    = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] awaddr_q;
   logic [7:0]  awid_q;
   logic [7:0]  awlen_q;
   logic        pat01_q;
   logic [31:0] wr_addr;
   logic [31:0] wr_addr_nx;
   logic [7:0]  beat_cnt;
   logic [63:0] wdata_q;
   logic        awvalid, wvalid, wlast, bready;
   logic        start, aw_hs, w_hs, b_hs, b_err;

   // Each lane's low byte is the random byte XOR its lane address,
   // so a reader can verify it from the data alone.
   function automatic logic [63:0] beat_data(
      input logic [7:0] r,
      input logic [7:0] a,
      input logic       p01
   );
      logic [63:0] d;
      d = '0;
      if (p01) begin
         d = 64'h0000_ffff_0000_ffff;
      end else begin
         for (int i = 0; i < 4; i++)
            d[16*i +: 16] = {r, r ^ (a + 8'(i))};
      end
      return d;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wlast   = 1'b0;
      bready  = 1'b0;
      case (state)
         IDLE: begin
            if (write_en) state_n = AW;
         end
         AW: begin
            awvalid = 1'b1;
            if (axi.axi_awready) state_n = W;
         end
         W: begin
            wvalid = 1'b1;
            wlast  = (beat_cnt == awlen_q);
            if (axi.axi_wready && wlast) state_n = B;
         end
         B: begin
            bready = 1'b1;
            if (axi.axi_bvalid) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign start      = (state == IDLE) & write_en;
   assign aw_hs      = awvalid & axi.axi_awready;
   assign w_hs       = wvalid & axi.axi_wready;
   assign b_hs       = bready & axi.axi_bvalid;
   assign b_err      = (axi.axi_bresp != 2'b00) |
                       (axi.axi_bid != awid_q);
   assign wr_addr_nx = wr_addr + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awaddr_q     <= '0;
         awid_q       <= '0;
         awlen_q      <= '0;
         pat01_q      <= 1'b0;
         wr_addr      <= '0;
         beat_cnt     <= '0;
         wdata_q      <= '0;
         write_done_p <= 1'b0;
         wr_err_cnt   <= '0;
         wr_err_flag  <= 1'b0;
      end else begin
         write_done_p <= b_hs;
         if (start) begin
            awaddr_q <= {{ADDR_NUM_BIT{1'b0}},
                         random_rw_addr, 1'b0};
            awid_q   <= {4'b0, random_axi_id};
            awlen_q  <= {4'b0, random_axi_len};
            pat01_q  <= data_pattern_01;
            wr_addr  <= {{(32-CTRL_ADDR_WIDTH){1'b0}},
                         random_rw_addr};
            beat_cnt <= '0;
         end
         if (aw_hs)
            wdata_q <= beat_data(random_data, wr_addr[7:0],
                                 pat01_q);
         // Next beat is loaded on the handshake edge: no bubbles.
         if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            wr_addr  <= wr_addr_nx;
            wdata_q  <= beat_data(random_data, wr_addr_nx[7:0],
                                  pat01_q);
         end
         if (b_hs && b_err) begin
            wr_err_flag <= 1'b1;
            if (wr_err_cnt != 8'hff)
               wr_err_cnt <= wr_err_cnt + 8'd1;
         end
      end
   end

   assign axi.axi_awaddr   = awaddr_q;
   assign axi.axi_awid     = awid_q;
   assign axi.axi_awlen    = awlen_q;
   assign axi.axi_awsize   = 3'b011;
   assign axi.axi_awburst  = 2'b01;
   assign axi.axi_awlock   = 1'b0;
   assign axi.axi_awqos    = 4'h0;
   assign axi.axi_awpoison = 1'b0;
   assign axi.axi_awurgent = 1'b0;
   assign axi.axi_awvalid  = awvalid;
   assign axi.axi_wdata    = wdata_q;
   assign axi.axi_wstrb    = 8'hff;
   assign axi.axi_wlast    = wlast;
   assign axi.axi_wvalid   = wvalid;
   assign axi.axi_bready   = bready;
endmodule

// File: tb/tb_test_wr_ctrl_64bit.sv
// Bench for test_wr_ctrl_64bit: acts as AXI slave, predicts every
// beat and error count from the data rule and driven stimulus.
module tb_test_wr_ctrl_64bit;
   logic        clk;
   logic        rst_n;
   logic [27:0] random_rw_addr;
   logic [3:0]  random_axi_id;
   logic [3:0]  random_axi_len;
   logic [7:0]  random_data;
   logic        write_en;
   logic        data_pattern_01;
   logic        write_done_p;
   logic [7:0]  wr_err_cnt;
   logic        wr_err_flag;

   test_wr_ctrl_64bit_if axi();

   test_wr_ctrl_64bit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .random_rw_addr  (random_rw_addr),
      .random_axi_id   (random_axi_id),
      .random_axi_len  (random_axi_len),
      .random_data     (random_data),
      .write_en        (write_en),
      .data_pattern_01 (data_pattern_01),
      .write_done_p    (write_done_p),
      .wr_err_cnt      (wr_err_cnt),
      .wr_err_flag     (wr_err_flag),
      .axi             (axi)
   );

   int          total;
   int          bad;
   int          err_exp;
   bit          flag_exp;
   logic [63:0] seen [16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] exp_beat(
      input logic [7:0] r,
      input int         a,
      input bit         pat
   );
      logic [63:0] d;
      int          la;
      int          lane;
      if (pat) return 64'h0000_ffff_0000_ffff;
      d = '0;
      for (int i = 0; i < 4; i++) begin
         la   = (a + i) % 256;
         lane = int'(r) * 256 + (int'(r) ^ la);
         d    = d | (64'(lane) << (16 * i));
      end
      return d;
   endfunction

   function automatic logic [125:0] rst_vec();
      return {axi.axi_awvalid, axi.axi_wvalid, axi.axi_wlast,
              axi.axi_bready, write_done_p, wr_err_flag,
              axi.axi_awaddr, axi.axi_awid, axi.axi_awlen,
              axi.axi_wdata, wr_err_cnt};
   endfunction

   // One complete burst, starting and ending on a falling edge.
   task automatic run_burst(
      input logic [27:0] addr,
      input logic [3:0]  id,
      input logic [3:0]  len,
      input bit          pat,
      input int          aw_stall,
      input int          w_mode,
      input logic [1:0]  bresp,
      input bit          bid_bad,
      input bit          keep_en,
      input bit          early_b,
      input bit          use_fr,
      input logic [7:0]  fr0,
      input logic [7:0]  fr1
   );
      logic [7:0]  rq [17];
      logic [63:0] exp;
      logic [31:0] exp_addr;
      logic [7:0]  bid_x;
      int          k;
      int          cyc;
      int          bdel;
      bit          rsp_bad;
      exp_addr = {3'b000, addr, 1'b0};
      random_rw_addr  = addr;
      random_axi_id   = id;
      random_axi_len  = len;
      data_pattern_01 = pat;
      write_en        = 1'b1;
      axi.axi_awready = 1'b0;
      axi.axi_wready  = 1'b0;
      axi.axi_bvalid  = 1'b0;
      random_data     = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (!keep_en) write_en = 1'b0;
      random_rw_addr  = 28'($urandom);
      random_axi_id   = 4'($urandom);
      random_axi_len  = 4'($urandom);
      data_pattern_01 = 1'($urandom);
      for (int c = 0; c <= aw_stall; c++) begin
         total++;
         if (axi.axi_awvalid !== 1'b1 ||
             axi.axi_awaddr !== exp_addr ||
             axi.axi_awid !== {4'b0, id} ||
             axi.axi_awlen !== {4'b0, len} ||
             axi.axi_wvalid !== 1'b0 ||
             write_done_p !== 1'b0) begin
            bad++;
            $display("FAIL aw_phase c=%0d got v=%b a=%h id=%h len=%h wv=%b dn=%b exp a=%h id=%h len=%h",
                     c, axi.axi_awvalid, axi.axi_awaddr,
                     axi.axi_awid, axi.axi_awlen,
                     axi.axi_wvalid, write_done_p,
                     exp_addr, id, len);
         end
         axi.axi_awready = (c == aw_stall);
         axi.axi_bvalid  = early_b;
         axi.axi_bresp   = 2'($urandom);
         axi.axi_bid     = 8'($urandom);
         random_data     = use_fr ? fr0 : 8'($urandom);
         rq[0]           = random_data;
         @(posedge clk);
         @(negedge clk);
      end
      axi.axi_awready = 1'b0;
      k   = 0;
      cyc = 0;
      while (k <= int'(len) && cyc < 200) begin
         case (w_mode)
            0:       axi.axi_wready = 1'b1;
            1:       axi.axi_wready = (cyc % 2 == 0);
            default: axi.axi_wready = 1'($urandom_range(0, 1));
         endcase
         exp = exp_beat(rq[k], int'(addr[7:0]) + 4 * k, pat);
         total++;
         if (axi.axi_wvalid !== 1'b1 ||
             axi.axi_wdata !== exp ||
             axi.axi_wlast !== (k == int'(len)) ||
             axi.axi_awvalid !== 1'b0 ||
             axi.axi_bready !== 1'b0 ||
             write_done_p !== 1'b0) begin
            bad++;
            $display("FAIL w_beat k=%0d got v=%b d=%h last=%b awv=%b br=%b dn=%b exp d=%h last=%b",
                     k, axi.axi_wvalid, axi.axi_wdata,
                     axi.axi_wlast, axi.axi_awvalid,
                     axi.axi_bready, write_done_p,
                     exp, (k == int'(len)));
         end
         random_data = 8'($urandom);
         if (axi.axi_wready) begin
            if (use_fr && k == 0) random_data = fr1;
            seen[k]  = axi.axi_wdata;
            rq[k+1]  = random_data;
            k++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      axi.axi_wready = 1'b0;
      if (cyc >= 200) begin
         total++;
         bad++;
         $display("FAIL w_timeout got beats=%0d exp=%0d",
                  k, int'(len) + 1);
      end
      bdel = $urandom_range(0, 2);
      for (int d = 0; d <= bdel; d++) begin
         total++;
         if (axi.axi_bready !== 1'b1 ||
             axi.axi_wvalid !== 1'b0 ||
             axi.axi_wlast !== 1'b0 ||
             write_done_p !== 1'b0) begin
            bad++;
            $display("FAIL b_wait d=%0d got br=%b wv=%b wl=%b dn=%b exp br=1 wv=0 wl=0 dn=0",
                     d, axi.axi_bready, axi.axi_wvalid,
                     axi.axi_wlast, write_done_p);
         end
         bid_x = {4'b0, id};
         if (bid_bad)
            bid_x = bid_x ^ (8'd1 << $urandom_range(0, 7));
         axi.axi_bvalid = (d == bdel);
         axi.axi_bresp  = bresp;
         axi.axi_bid    = bid_x;
         @(posedge clk);
         @(negedge clk);
      end
      axi.axi_bvalid = 1'b0;
      rsp_bad = (bresp != 2'b00) || bid_bad;
      if (rsp_bad) begin
         flag_exp = 1'b1;
         if (err_exp < 255) err_exp++;
      end
      total++;
      if (write_done_p !== 1'b1 ||
          axi.axi_bready !== 1'b0 ||
          axi.axi_awvalid !== 1'b0 ||
          wr_err_cnt !== 8'(err_exp) ||
          wr_err_flag !== flag_exp) begin
         bad++;
         $display("FAIL b_done got dn=%b br=%b awv=%b cnt=%0d flag=%b exp dn=1 br=0 awv=0 cnt=%0d flag=%b",
                  write_done_p, axi.axi_bready,
                  axi.axi_awvalid, wr_err_cnt, wr_err_flag,
                  err_exp, flag_exp);
      end
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      write_en        = 1'b0;
      data_pattern_01 = 1'b0;
      random_rw_addr  = '0;
      random_axi_id   = '0;
      random_axi_len  = '0;
      random_data     = '0;
      axi.axi_awready = 1'b0;
      axi.axi_wready  = 1'b0;
      axi.axi_bvalid  = 1'b0;
      axi.axi_bresp   = 2'b00;
      axi.axi_bid     = 8'h00;
      err_exp         = 0;
      flag_exp        = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (rst_vec() !== '0) begin
         bad++;
         $display("FAIL reset_vals got=%h exp=0", rst_vec());
      end
      total++;
      if ({axi.axi_awsize, axi.axi_awburst, axi.axi_wstrb,
           axi.axi_awlock, axi.axi_awqos, axi.axi_awpoison,
           axi.axi_awurgent} !== {3'b011, 2'b01, 8'hff, 7'd0}) begin
         bad++;
         $display("FAIL const_fields got size=%h burst=%h strb=%h exp 3 1 ff",
                  axi.axi_awsize, axi.axi_awburst, axi.axi_wstrb);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (axi.axi_awvalid !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_aw got=%b exp=0", axi.axi_awvalid);
      end
   endtask

   task automatic test_directed();
      run_burst(28'h000007E, 4'd3, 4'd1, 1'b0, 0, 0, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h3C);
      total++;
      if (seen[0] !== 64'h5ADB_5ADA_5A25_5A24) begin
         bad++;
         $display("FAIL directed_b0 got=%h exp=%h",
                  seen[0], 64'h5ADB_5ADA_5A25_5A24);
      end
      total++;
      if (seen[1] !== 64'h3CB9_3CB8_3CBF_3CBE) begin
         bad++;
         $display("FAIL directed_b1 got=%h exp=%h",
                  seen[1], 64'h3CB9_3CB8_3CBF_3CBE);
      end
   endtask

   task automatic test_lane_wrap();
      run_burst(28'h01230FC, 4'd7, 4'd1, 1'b0, 0, 0, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00);
      total++;
      if (seen[0] !== 64'h5AA5_5AA4_5AA7_5AA6) begin
         bad++;
         $display("FAIL wrap_b0 got=%h exp=%h",
                  seen[0], 64'h5AA5_5AA4_5AA7_5AA6);
      end
      total++;
      if (seen[1] !== 64'h0003_0002_0001_0000) begin
         bad++;
         $display("FAIL wrap_b1 got=%h exp=%h",
                  seen[1], 64'h0003_0002_0001_0000);
      end
   endtask

   task automatic test_pattern01();
      run_burst(28'($urandom), 4'd5, 4'd15, 1'b1, 0, 1, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_aw_stall();
      run_burst(28'($urandom), 4'd2, 4'd3, 1'b0, 5, 0, 2'b00,
                1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         run_burst(28'($urandom), 4'($urandom), 4'($urandom),
                   1'b0, 0, 2, 2'b00, 1'b0, (i < 2), 1'b0,
                   1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         run_burst(28'($urandom), 4'($urandom), 4'($urandom),
                   ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 3), 2, 2'b00, 1'b0,
                   1'($urandom), 1'($urandom), 1'b0,
                   8'h00, 8'h00);
   endtask

   task automatic test_errors();
      run_burst(28'($urandom), 4'd4, 4'd0, 1'b0, 0, 0, 2'b10,
                1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      run_burst(28'($urandom), 4'd6, 4'd2, 1'b0, 0, 0, 2'b00,
                1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      total++;
      if (wr_err_cnt !== 8'd2 || wr_err_flag !== 1'b1) begin
         bad++;
         $display("FAIL err_two got cnt=%0d flag=%b exp cnt=2 flag=1",
                  wr_err_cnt, wr_err_flag);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++)
         run_burst(28'($urandom), 4'($urandom), 4'd0, 1'b0, 0, 0,
                   2'($urandom_range(1, 3)), 1'($urandom),
                   1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      total++;
      if (wr_err_cnt !== 8'hff || wr_err_flag !== 1'b1) begin
         bad++;
         $display("FAIL err_sat got cnt=%h flag=%b exp cnt=ff flag=1",
                  wr_err_cnt, wr_err_flag);
      end
   endtask

   task automatic test_reset_mid_burst();
      int nhs;
      int cyc;
      nhs = 0;
      cyc = 0;
      random_rw_addr  = 28'h0123456;
      random_axi_id   = 4'h9;
      random_axi_len  = 4'd7;
      data_pattern_01 = 1'b0;
      write_en        = 1'b1;
      axi.axi_awready = 1'b1;
      axi.axi_wready  = 1'b1;
      axi.axi_bvalid  = 1'b0;
      random_data     = 8'($urandom);
      while (nhs < 3 && cyc < 50) begin
         if (axi.axi_wvalid === 1'b1) nhs++;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      total++;
      if (axi.axi_wvalid !== 1'b1 || nhs != 3) begin
         bad++;
         $display("FAIL mid_w got wv=%b beats=%0d exp wv=1 beats=3",
                  axi.axi_wvalid, nhs);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (rst_vec() !== '0) begin
         bad++;
         $display("FAIL mid_reset got=%h exp=0", rst_vec());
      end
      err_exp  = 0;
      flag_exp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (write_done_p !== 1'b0 || axi.axi_awvalid !== 1'b0 ||
             axi.axi_wvalid !== 1'b0) begin
            bad++;
            $display("FAIL in_reset i=%0d got dn=%b awv=%b wv=%b exp 0 0 0",
                     i, write_done_p, axi.axi_awvalid,
                     axi.axi_wvalid);
         end
      end
      rst_n = 1'b1;
      run_burst(28'h0ABCDEF, 4'hC, 4'd2, 1'b0, 1, 0, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_directed();
      test_lane_wrap();
      test_pattern01();
      test_aw_stall();
      test_back_to_back();
      test_random();
      test_errors();
      test_saturation();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
